alu_result_checker: RTL and testbench

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker.sv | 97 +++++++++
 tb/tb_alu_result_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// alu_result_checker: scores a bitwise gate's results against a two-stage reference pipeline
// and reports per-session pass/fail counts plus the first failing vector.
module alu_result_checker #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             done,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] dut_out,
    output logic [1:0]       state,
    output logic [15:0]      pass_count,
    output logic [15:0]      fail_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_got,
    output logic [WIDTH-1:0] fail_exp,
    output logic [1:0]       fail_op
);
    // Low two bits of each encoding are the reported state, so DRAIN shows as RUN.
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        RUN   = 3'b001,
        DRAIN = 3'b101,
        PASS  = 3'b010,
        FAIL  = 3'b011
    } st_t;
    st_t              st;
    logic             dc;
    logic             v1, v2, m2;
    logic [1:0]       op1, op2;
    logic [WIDTH-1:0] a1, b1, o1, a2, b2, got2, exp2, exp1;
    logic [15:0]      fail_nxt;
    assign state = st[1:0];
    always_comb begin
        exp1 = op1 == 2'b00 ? a1 & b1 :
               op1 == 2'b01 ? a1 | b1 :
               op1 == 2'b10 ? a1 ^ b1 : ~a1;
        fail_nxt = v2 && m2 && fail_count != 16'hFFFF ? fail_count + 16'd1 : fail_count;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst || start) begin
            st         <= rst ? IDLE : RUN;
            dc         <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            m2         <= 1'b0;
            op1        <= '0;
            op2        <= '0;
            a1         <= '0;
            b1         <= '0;
            o1         <= '0;
            a2         <= '0;
            b2         <= '0;
            got2       <= '0;
            exp2       <= '0;
            pass_count <= '0;
            fail_count <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
            fail_op    <= '0;
        end else begin
            v1   <= st == RUN && in_valid;
            op1  <= op;
            a1   <= a;
            b1   <= b;
            o1   <= dut_out;
            v2   <= v1;
            m2   <= exp1 != o1;
            op2  <= op1;
            a2   <= a1;
            b2   <= b1;
            got2 <= o1;
            exp2 <= exp1;
            if (v2 && !m2 && pass_count != 16'hFFFF)
                pass_count <= pass_count + 16'd1;
            fail_count <= fail_nxt;
            // fail_count never returns to zero within a session, so zero marks the first mismatch
            if (v2 && m2 && fail_count == 16'd0) begin
                fail_a   <= a2;
                fail_b   <= b2;
                fail_got <= got2;
                fail_exp <= exp2;
                fail_op  <= op2;
            end
            dc <= st == DRAIN;
            st <= st == RUN && done ? DRAIN :
                  st == DRAIN && dc ? (fail_nxt != 16'd0 ? FAIL : PASS) : st;
        end
    end
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed single-vector session table plus hand sequences for
// multi-vector sessions, restart, async reset and ignored input.
module tb_alu_result_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, done = 1'b0, in_valid = 1'b0;
    logic [1:0]  op = '0;
    logic [15:0] a = '0, b = '0, dut_out = '0;
    logic [1:0]  state, fail_op;
    logic [15:0] pass_count, fail_count, fail_a, fail_b, fail_got, fail_exp;
    int checks = 0, errors = 0;

    alu_result_checker #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .in_valid(in_valid),
        .op(op), .a(a), .b(b), .dut_out(dut_out), .state(state),
        .pass_count(pass_count), .fail_count(fail_count), .fail_a(fail_a),
        .fail_b(fail_b), .fail_got(fail_got), .fail_exp(fail_exp), .fail_op(fail_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b, dout;
        logic        ok;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [15:0] ref_fn(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~x;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] d, input logic dn);
        in_valid = 1'b1; op = o; a = x; b = y; dut_out = d; done = dn;
        tick();
        in_valid = 1'b0; done = 1'b0;
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{2'b01, 16'h1082, 16'h1082, 16'h1082, 1'b1, 16'h1082};
        tbl[1] = '{2'b00, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b1, 16'h00F0};
        tbl[2] = '{2'b10, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b1, 16'hFF00};
        tbl[3] = '{2'b11, 16'h1234, 16'h5A5A, 16'hEDCB, 1'b1, 16'hEDCB};
        tbl[4] = '{2'b00, 16'hAAAA, 16'h5555, 16'h0001, 1'b0, 16'h0000};
        tbl[5] = '{2'b11, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF};
        tbl[6] = '{2'b10, 16'h8001, 16'h0001, 16'h8001, 1'b0, 16'h8000};
        tbl[7] = '{2'b01, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b1, 16'h0FF0};

        #1;
        chk("reset_state", state, 2'b00);
        chk("reset_pass", pass_count, 0);
        chk("reset_fail", fail_count, 0);
        chk("reset_capture", {fail_a, fail_b, fail_got, fail_exp, 14'd0, fail_op}, 0);
        tick();
        rst = 1'b0;
        tick();

        // Each entry: one vector arriving together with done, then two drain cycles.
        for (int i = 0; i < 8; i++) begin
            begin_session();
            chk("tbl_run", state, 2'b01);
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dout, 1'b1);
            tick();
            chk("tbl_drain", state, 2'b01);
            tick();
            chk("tbl_state", state, tbl[i].ok ? 2'b10 : 2'b11);
            chk("tbl_pass", pass_count, tbl[i].ok ? 1 : 0);
            chk("tbl_fail", fail_count, tbl[i].ok ? 0 : 1);
            if (!tbl[i].ok) begin
                chk("tbl_fail_exp", fail_exp, tbl[i].exp);
                chk("tbl_fail_got", fail_got, tbl[i].dout);
                chk("tbl_fail_a", fail_a, tbl[i].a);
                chk("tbl_fail_b", fail_b, tbl[i].b);
                chk("tbl_fail_op", fail_op, tbl[i].op);
            end
        end

        // Mixed session: two matches, one xor mismatch.
        begin_session();
        chk("mix_cleared", {pass_count, fail_count, fail_exp}, 0);
        send(2'b01, 16'h4648, 16'h1082, 16'h56CA, 1'b0);
        send(2'b00, 16'h4648, 16'h1082, 16'h0000, 1'b0);
        send(2'b10, 16'hA4F1, 16'h1082, 16'hFFFF, 1'b1);
        tick();
        tick();
        chk("mix_state", state, 2'b11);
        chk("mix_pass", pass_count, 2);
        chk("mix_fail", fail_count, 1);
        chk("mix_fail_exp", fail_exp, 16'hB473);
        chk("mix_fail_got", fail_got, 16'hFFFF);
        chk("mix_fail_op", fail_op, 2'b10);
        // Holds while idle in FAIL, ignoring further vectors.
        send(2'b01, 16'h0001, 16'h0002, 16'h0003, 1'b0);
        tick();
        tick();
        chk("fail_hold_state", state, 2'b11);
        chk("fail_hold_pass", pass_count, 2);

        // Back-to-back mismatches: only the first is captured.
        begin_session();
        send(2'b11, 16'h8003, 16'h0000, 16'h0000, 1'b0);
        send(2'b01, 16'h0011, 16'h1082, 16'h0000, 1'b1);
        tick();
        tick();
        chk("b2b_fail", fail_count, 2);
        chk("b2b_fail_a", fail_a, 16'h8003);
        chk("b2b_fail_exp", fail_exp, 16'h7FFC);
        chk("b2b_fail_op", fail_op, 2'b11);
        chk("b2b_state", state, 2'b11);

        // Ten matching vectors at full rate, done with the last one.
        begin_session();
        for (int i = 0; i < 10; i++) begin
            logic [15:0] x;
            x = 16'(i * 16'h1111);
            send(2'(i % 4), x, 16'h0F0F, ref_fn(2'(i % 4), x, 16'h0F0F), i == 9);
        end
        chk("burst_lat_n", pass_count, 8);
        tick();
        chk("burst_lat_n1", pass_count, 9);
        chk("burst_drain", state, 2'b01);
        tick();
        chk("burst_pass", pass_count, 10);
        chk("burst_state", state, 2'b10);

        // Asynchronous reset mid-cycle with two vectors still in the pipeline.
        begin_session();
        send(2'b00, 16'hFFFF, 16'h00FF, 16'h00FF, 1'b0);
        send(2'b00, 16'hFFFF, 16'h00FF, 16'h00FF, 1'b0);
        send(2'b00, 16'hFFFF, 16'h00FF, 16'h0000, 1'b0);
        chk("rst_pre_pass", pass_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_state", state, 2'b00);
        chk("rst_async_pass", pass_count, 0);
        #1 rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_start_honoured", state, 2'b01);
        tick();
        tick();
        tick();
        chk("rst_no_stale_pass", pass_count, 0);
        chk("rst_no_stale_fail", fail_count, 0);

        // start together with done in RUN restarts rather than draining.
        send(2'b10, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b0);
        tick();
        tick();
        chk("restart_pre", pass_count, 1);
        start = 1'b1; done = 1'b1;
        tick();
        start = 1'b0; done = 1'b0;
        chk("restart_state", state, 2'b01);
        chk("restart_pass", pass_count, 0);
        tick();
        tick();
        chk("restart_still_run", state, 2'b01);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        chk("empty_pass_state", state, 2'b10);

        // Vectors offered in IDLE are ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) send(2'b01, 16'h0001, 16'h0002, 16'h0003, 1'b0);
        tick();
        tick();
        chk("idle_state", state, 2'b00);
        chk("idle_pass", pass_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
